// File: rtl/etroc2_fc_pkg.sv
// Shared definitions for the fast-command charge-injection path.
// Holds the BCID range, the sequencer state encoding and helpers that
// map the raw programming registers onto their effective values.
package etroc2_fc_pkg;

    localparam int          BCID_WIDTH      = 12;
    localparam logic [11:0] BCID_MAX        = 12'd3563;
    localparam int          MIN_L1A_LATENCY = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        INJECT = 2'd1,
        WAIT   = 2'd2
    } state_t;

    // A programmed period of 0 means back-to-back injections.
    function automatic logic [7:0] effective_period(input logic [7:0] period);
        return (period == 8'd0) ? 8'd1 : period;
    endfunction

    // The due-time pipeline needs at least two cycles between the push
    // and the registered selfL1A output, so shorter latencies are raised.
    function automatic logic [8:0] effective_latency(input logic [8:0] latency);
        return (latency < 9'(MIN_L1A_LATENCY)) ? 9'(MIN_L1A_LATENCY) : latency;
    endfunction

endpackage

// File: rtl/l1a_due_fifo.sv
// Synchronous FIFO of self-L1A due-times.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   push, din  : write request and due-time to store
//   pop        : remove the head entry (ignored when empty)
//   full/empty : occupancy flags
//   head       : oldest stored due-time
// A push while full is accepted only if a pop happens in the same cycle;
// otherwise it is dropped and the caller flags the overflow.
module l1a_due_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_pop;
    logic             do_push;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once counted in.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/charge_injection_scheduler.sv
// Charge-injection burst sequencer with self-trigger L1A generation.
// Turns one fcQinj strobe into injCount one-cycle chargeInjectionCmd
// pulses spaced injPeriod BX apart, and schedules a selfL1A a fixed
// latency after each pulse.
// Ports:
//   clk40, reset        : 40 MHz clock, synchronous active-high reset
//   enable              : scheduler enable; dropping it aborts a burst
//   fcQinj, fcBCR       : one-cycle fast-command strobes
//   injCount/injPeriod  : burst length and spacing
//   l1aLatency          : injection-to-selfL1A delay in cycles
//   selfL1AEn           : schedule self-L1As for each injection
//   chargeInjectionCmd  : one-cycle pulse to the pulse generator
//   selfL1A             : one-cycle self-trigger
//   injBcid             : BCID of the most recent injection
//   busy                : burst in progress
//   l1aOverflow         : sticky, a self-L1A was dropped (FIFO full)
//   fsmState            : sequencer state, for observation
// Handshake: strobes are single-cycle pulses with no back-pressure;
// an fcQinj arriving while busy is discarded.
module charge_injection_scheduler
    import etroc2_fc_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMER_WIDTH = 10
) (
    input  logic        clk40,
    input  logic        reset,
    input  logic        enable,
    input  logic        fcQinj,
    input  logic        fcBCR,
    input  logic [7:0]  injCount,
    input  logic [7:0]  injPeriod,
    input  logic [8:0]  l1aLatency,
    input  logic        selfL1AEn,
    output logic        chargeInjectionCmd,
    output logic        selfL1A,
    output logic [11:0] injBcid,
    output logic        busy,
    output logic        l1aOverflow,
    output state_t      fsmState
);

    state_t                 state;
    logic [7:0]             remaining;
    logic [7:0]             gap;
    logic [BCID_WIDTH-1:0]  bcid;
    logic [TIMER_WIDTH-1:0] timer;
    logic [TIMER_WIDTH-1:0] timer_next;
    logic [TIMER_WIDTH-1:0] due_time;
    logic [7:0]             eff_period;
    logic [8:0]             eff_latency;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [TIMER_WIDTH-1:0] fifo_head;

    assign eff_period  = effective_period(injPeriod);
    assign eff_latency = effective_latency(l1aLatency);
    assign timer_next  = timer + TIMER_WIDTH'(1);
    assign due_time    = timer + TIMER_WIDTH'(eff_latency);
    assign fsmState    = state;

    // Every INJECT cycle is a real pulse, so it schedules a trigger.
    assign fifo_push = (state == INJECT) && selfL1AEn;
    // selfL1A is registered, so the head is matched against the timer
    // value of the coming cycle; modular equality makes wrap harmless.
    assign fifo_pop  = !fifo_empty && (fifo_head == timer_next);

    l1a_due_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (TIMER_WIDTH)
    ) u_fifo (
        .clk   (clk40),
        .reset (reset),
        .push  (fifo_push),
        .din   (due_time),
        .pop   (fifo_pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    // Burst sequencer. Outputs are decided together with the next state
    // so chargeInjectionCmd and busy line up with the state they describe.
    always_ff @(posedge clk40) begin
        if (reset) begin
            state              <= IDLE;
            remaining          <= '0;
            gap                <= '0;
            chargeInjectionCmd <= 1'b0;
            busy               <= 1'b0;
            injBcid            <= '0;
        end else begin
            chargeInjectionCmd <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (fcQinj && enable && (injCount != 8'd0)) begin
                        remaining          <= injCount;
                        state              <= INJECT;
                        chargeInjectionCmd <= 1'b1;
                        busy               <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                INJECT: begin
                    injBcid   <= bcid;
                    remaining <= remaining - 8'd1;
                    if (!enable || (remaining == 8'd1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (eff_period == 8'd1) begin
                        state              <= INJECT;
                        chargeInjectionCmd <= 1'b1;
                    end else begin
                        state <= WAIT;
                        gap   <= eff_period - 8'd1;
                    end
                end
                WAIT: begin
                    gap <= gap - 8'd1;
                    if (!enable) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (gap == 8'd1) begin
                        state              <= INJECT;
                        chargeInjectionCmd <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // BCID counter, cycle timer and self-trigger output.
    always_ff @(posedge clk40) begin
        if (reset) begin
            bcid        <= '0;
            timer       <= '0;
            selfL1A     <= 1'b0;
            l1aOverflow <= 1'b0;
        end else begin
            if (fcBCR)                  bcid <= '0;
            else if (bcid == BCID_MAX)  bcid <= '0;
            else                        bcid <= bcid + 1'b1;
            timer   <= timer_next;
            selfL1A <= fifo_pop;
            if (fifo_push && fifo_full && !fifo_pop) l1aOverflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_charge_injection_scheduler.sv
module tb_charge_injection_scheduler;
  import etroc2_fc_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk40 = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        fcQinj = 1'b0;
  logic        fcBCR = 1'b0;
  logic [7:0]  injCount = 8'd1;
  logic [7:0]  injPeriod = 8'd1;
  logic [8:0]  l1aLatency = 9'd20;
  logic        selfL1AEn = 1'b1;
  logic        chargeInjectionCmd;
  logic        selfL1A;
  logic [11:0] injBcid;
  logic        busy;
  logic        l1aOverflow;
  state_t      fsmState;

  always #5 clk40 = ~clk40;

  int cyc = 0;
  always @(posedge clk40) cyc <= cyc + 1;

  charge_injection_scheduler #(.FIFO_DEPTH(8), .TIMER_WIDTH(10)) dut (
    .clk40              (clk40),
    .reset              (reset),
    .enable             (enable),
    .fcQinj             (fcQinj),
    .fcBCR              (fcBCR),
    .injCount           (injCount),
    .injPeriod          (injPeriod),
    .l1aLatency         (l1aLatency),
    .selfL1AEn          (selfL1AEn),
    .chargeInjectionCmd (chargeInjectionCmd),
    .selfL1A            (selfL1A),
    .injBcid            (injBcid),
    .busy               (busy),
    .l1aOverflow        (l1aOverflow),
    .fsmState           (fsmState)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_cmd_q[$];
  logic [31:0] exp_l1a_q[$];
  logic [31:0] obs_cmd_q[$];
  logic [31:0] obs_l1a_q[$];
  int busy_cnt = 0;

  always @(negedge clk40) begin
    if (chargeInjectionCmd) obs_cmd_q.push_back(32'(cyc));
    if (selfL1A) obs_l1a_q.push_back(32'(cyc));
    if (busy) busy_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic compare_events(input string tag, input int exp_busy);
    check_eq({tag, "_cmd_count"}, 32'(obs_cmd_q.size()), 32'(exp_cmd_q.size()));
    for (int i = 0; i < exp_cmd_q.size(); i++)
      check_eq($sformatf("%s_cmd%0d", tag, i),
               (i < obs_cmd_q.size()) ? obs_cmd_q[i] : 32'hffffffff, exp_cmd_q[i]);
    check_eq({tag, "_l1a_count"}, 32'(obs_l1a_q.size()), 32'(exp_l1a_q.size()));
    for (int i = 0; i < exp_l1a_q.size(); i++)
      check_eq($sformatf("%s_l1a%0d", tag, i),
               (i < obs_l1a_q.size()) ? obs_l1a_q[i] : 32'hffffffff, exp_l1a_q[i]);
    check_eq({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
    exp_cmd_q.delete();
    exp_l1a_q.delete();
    obs_cmd_q.delete();
    obs_l1a_q.delete();
    busy_cnt = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_cmd"}, 32'(chargeInjectionCmd), 32'd0);
    check_eq({tag, "_selfl1a"}, 32'(selfL1A), 32'd0);
    check_eq({tag, "_injbcid"}, 32'(injBcid), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_overflow"}, 32'(l1aOverflow), 32'd0);
    check_eq({tag, "_state"}, 32'(fsmState), 32'(IDLE));
  endtask

  // ---------------- driver tasks ----------------
  // Lands 1 time unit after the posedge that starts cycle c.
  task automatic goto_cycle(input int c);
    while (cyc < c) begin
      @(posedge clk40);
      #1;
    end
  endtask

  task automatic qinj(input int c);
    goto_cycle(c);
    fcQinj = 1'b1;
    goto_cycle(c + 1);
    fcQinj = 1'b0;
  endtask

  task automatic expect_range(input int first, input int num, input int step, input bit is_l1a);
    for (int k = 0; k < num; k++) begin
      if (is_l1a) exp_l1a_q.push_back(32'(first + k * step));
      else        exp_cmd_q.push_back(32'(first + k * step));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    goto_cycle(3);
    check_all_zero("reset");
    reset = 1'b0;
    busy_cnt = 0;

    // single injection, latency 20
    injCount = 8'd1; injPeriod = 8'd1; l1aLatency = 9'd20; selfL1AEn = 1'b1;
    qinj(10);
    expect_range(11, 1, 1, 1'b0);
    expect_range(31, 1, 1, 1'b1);
    goto_cycle(40);
    compare_events("single", 1);

    // 4 injections, period 3, ignored strobe mid-burst
    injCount = 8'd4; injPeriod = 8'd3; l1aLatency = 9'd5;
    qinj(50);
    qinj(55);
    expect_range(51, 4, 3, 1'b0);
    expect_range(56, 4, 3, 1'b1);
    goto_cycle(60);
    check_eq("burst4_busy_last", 32'(busy), 32'd1);
    goto_cycle(61);
    check_eq("burst4_busy_after", 32'(busy), 32'd0);
    goto_cycle(70);
    compare_events("burst4", 10);

    // 10 back-to-back injections into an 8-deep FIFO
    check_eq("overflow_before", 32'(l1aOverflow), 32'd0);
    injCount = 8'd10; injPeriod = 8'd1; l1aLatency = 9'd100;
    qinj(80);
    expect_range(81, 10, 1, 1'b0);
    expect_range(181, 8, 1, 1'b1);
    goto_cycle(95);
    check_eq("overflow_set", 32'(l1aOverflow), 32'd1);
    goto_cycle(200);
    compare_events("overflow", 10);
    check_eq("overflow_sticky", 32'(l1aOverflow), 32'd1);

    // enable dropped while waiting: burst stops, queued L1A survives
    injCount = 8'd5; injPeriod = 8'd2; l1aLatency = 9'd4;
    qinj(210);
    goto_cycle(212);
    enable = 1'b0;
    goto_cycle(213);
    enable = 1'b1;
    expect_range(211, 1, 1, 1'b0);
    expect_range(215, 1, 1, 1'b1);
    goto_cycle(230);
    compare_events("abort", 2);

    // period 0 -> 1, latency 0 -> 2
    injCount = 8'd3; injPeriod = 8'd0; l1aLatency = 9'd0;
    qinj(240);
    expect_range(241, 3, 1, 1'b0);
    expect_range(243, 3, 1, 1'b1);
    goto_cycle(255);
    compare_events("clamp", 3);

    // count 0 -> nothing happens
    injCount = 8'd0;
    qinj(260);
    goto_cycle(262);
    check_eq("count0_state", 32'(fsmState), 32'(IDLE));
    goto_cycle(270);
    compare_events("count0", 0);

    // reset during WAIT of a 5-injection burst
    injCount = 8'd5; injPeriod = 8'd4; l1aLatency = 9'd3;
    qinj(280);
    goto_cycle(286);
    check_eq("rst_state_wait", 32'(fsmState), 32'(WAIT));
    reset = 1'b1;
    goto_cycle(287);
    check_all_zero("midreset");
    reset = 1'b0;
    expect_range(281, 2, 4, 1'b0);
    expect_range(284, 1, 1, 1'b1);
    goto_cycle(310);
    compare_events("midreset", 6);

    // BCID: BCR at 320 -> counter 0 in 321; injection at 370 -> 49
    injCount = 8'd1; injPeriod = 8'd1; selfL1AEn = 1'b0;
    goto_cycle(320);
    fcBCR = 1'b1;
    goto_cycle(321);
    fcBCR = 1'b0;
    qinj(369);
    goto_cycle(371);
    check_eq("bcid_after_bcr", 32'(injBcid), 32'd49);

    // wrap: counter is 3563 in cycle 3884 and 0 in 3885
    injCount = 8'd2;
    qinj(3883);
    goto_cycle(3885);
    check_eq("bcid_max", 32'(injBcid), 32'd3563);
    goto_cycle(3886);
    check_eq("bcid_wrap", 32'(injBcid), 32'd0);
    expect_range(370, 1, 1, 1'b0);
    expect_range(3884, 2, 1, 1'b0);
    goto_cycle(3890);
    compare_events("bcid", 3);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/charge_injection_scheduler.md
# charge_injection_scheduler

Clk40-domain sequencer directly upstream of the charge-injection pulse generator. It converts a single decoded fast-command charge-injection strobe into a programmable burst of one-cycle `chargeInjectionCmd` pulses. It also emits a self-trigger L1A a fixed latency after each injection, for on-chip calibration without an external trigger. It sits between the fast-command decoder and the pulse generator / L1A path.

## Interface
Parameters:
- `FIFO_DEPTH`, 8, pending self-L1A slots (power of 2)
- `TIMER_WIDTH`, 10, free-running cycle timer width; must satisfy 2^TIMER_WIDTH > max latency

Ports:
- `clk40`  in  1  40 MHz clock; sole clock
- `reset`  in  1  synchronous, active-high reset
- `enable`  in  1  scheduler enable
- `fcQinj`  in  1  one-cycle charge-injection strobe from the fast-command decoder
- `fcBCR`  in  1  one-cycle bunch-counter reset strobe
- `injCount`  in  8  injections per burst; 0 = none
- `injPeriod`  in  8  BX spacing between injections; 0 is treated as 1
- `l1aLatency`  in  9  cycles from injection to self-L1A; values <2 are treated as 2
- `selfL1AEn`  in  1  enable self-L1A generation
- `chargeInjectionCmd`  out  1  one-cycle injection command to the pulse generator
- `selfL1A`  out  1  one-cycle self-trigger
- `injBcid`  out  12  BCID captured at the most recent injection
- `busy`  out  1  burst in progress
- `l1aOverflow`  out  1  sticky: a self-L1A was dropped because the FIFO was full

## Operation
- BCID counter: 0..3563, increments each cycle, wraps 3563→0. `fcBCR` loads 0 on the next edge and has priority over the increment.
- FSM states and transitions:
  - IDLE: on `fcQinj & enable & injCount!=0`, load remaining=`injCount` and go to INJECT.
  - INJECT: `chargeInjectionCmd`=1 for exactly this cycle. Capture `injBcid`=current BCID. Push due-time = timer + effective latency when `selfL1AEn`. Decrement remaining. Go to IDLE if remaining becomes 0, else go to WAIT with gap = effective period − 1. If effective period is 1, go directly back to INJECT.
  - WAIT: decrement gap; at 0 go to INJECT.
- `busy` = state != IDLE.
- `fcQinj` while busy is ignored; no queueing.
- `enable` deasserted in INJECT/WAIT: return to IDLE on the next edge with no further injections. Queued self-L1As are still delivered.
- `injCount`, `injPeriod` and `l1aLatency` are sampled when used. Changing them mid-burst is legal but not a verified use case.
- Self-L1A FIFO:
  - Entries are TIMER_WIDTH-bit due-times, in increasing order.
  - `selfL1A`=1 in the cycle where head due-time == timer; the head is popped in the same cycle.
  - A push when full drops the entry and sets `l1aOverflow`. It clears only on reset.
  - A push and a pop in the same cycle while full is allowed and does not overflow.
- Timer: free-running TIMER_WIDTH-bit counter with modular wrap; equality compare is wrap-safe.

## Timing
- Reset values: all outputs 0, state IDLE, BCID 0, timer 0, FIFO empty.
- `fcQinj` high at edge N → `chargeInjectionCmd` high in cycle N+1. The k-th injection (k from 0) is at N+1+k·P, where P is the effective period.
- Injection at cycle T → `selfL1A` high at cycle T+L, where L is the effective latency.
- All outputs are registered; no combinational input→output paths.
- Reset asserted mid-burst: next cycle returns to the reset state, pending L1As are discarded, and no pulse is emitted.

## Structure
- Shared package `etroc2_fc_pkg`:
  - BCID_MAX = 3563
  - BCID width = 12
  - FSM state enum {IDLE, INJECT, WAIT}
  - MIN_L1A_LATENCY = 2
- Sub-module `l1a_due_fifo`: synchronous FIFO of due-times with push, pop, full, empty and head.

## Test plan
- `injCount`=1, `fcQinj` at cycle 10, `selfL1AEn`=1, `l1aLatency`=20 → `chargeInjectionCmd` at 11 only; `selfL1A` at 31; `busy` high for 1 cycle.
- `injCount`=4, `injPeriod`=3 → pulses at N+1, N+4, N+7, N+10; `busy` deasserts after the 4th; a second `fcQinj` at N+5 is ignored.
- `injCount`=10, `injPeriod`=1, `l1aLatency`=100, `FIFO_DEPTH`=8 → 8 `selfL1A` delivered, `l1aOverflow`=1.
- `fcBCR` at cycle 100 and injection at cycle 150 → `injBcid`=49 (the counter is 0 at cycle 101). Free-running BCID reaches 3563 then 0.
- Reset asserted in WAIT of a 5-injection burst → no further pulses or `selfL1A`; all outputs 0 the next cycle.
- `injPeriod`=0 and `l1aLatency`=0 → behave as period 1 and latency 2; `injCount`=0 → no pulse and `busy` stays 0.
